// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the CP0 exception/interrupt sequencer:
// cause codes, Status bit positions, FSM encoding and a mask helper.
package exc_ctrl_pkg;

   localparam logic [4:0] CAUSE_INT_DEF = 5'd0;
   localparam logic [4:0] CAUSE_SYS_DEF = 5'd8;
   localparam logic [4:0] CAUSE_BRK_DEF = 5'd9;
   localparam logic [4:0] CAUSE_TEQ_DEF = 5'd13;

   localparam int IE     = 0;
   localparam int SYS_EN = 1;
   localparam int BRK_EN = 2;
   localparam int TEQ_EN = 3;
   localparam int INT_EN = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   // An event is enabled only when the global IE bit and its own bit are set.
   function automatic logic ev_enabled(input logic [31:0] status, input int bit_idx);
      return status[IE] & status[bit_idx];
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bus between the EX stage / CP0 and the exception sequencer.
// master = pipeline/CP0 side, slave = the sequencer.
interface exc_ctrl_if;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_syscall;
   logic        ex_break;
   logic        ex_teq;
   logic        ex_eret;
   logic        ex_mtc0;
   logic        ext_int;
   logic [31:0] status;

   logic        cp0_exception;
   logic        cp0_eret;
   logic [4:0]  cp0_cause;
   logic [31:0] cp0_pc;
   logic        flush;
   logic        redirect;
   logic        busy;
   logic        int_pending;

   modport master (
      output ex_valid, ex_pc, ex_syscall, ex_break, ex_teq, ex_eret, ex_mtc0,
             ext_int, status,
      input  cp0_exception, cp0_eret, cp0_cause, cp0_pc, flush, redirect,
             busy, int_pending
   );

   modport slave (
      input  ex_valid, ex_pc, ex_syscall, ex_break, ex_teq, ex_eret, ex_mtc0,
             ext_int, status,
      output cp0_exception, cp0_eret, cp0_cause, cp0_pc, flush, redirect,
             busy, int_pending
   );
endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational priority/mask encoder: picks the single event to service
// this cycle (eret > teq > break > syscall > interrupt) after Status masking.
module exc_prio_enc
   import exc_ctrl_pkg::*;
#(
   parameter logic [4:0] CAUSE_INT = CAUSE_INT_DEF,
   parameter logic [4:0] CAUSE_SYS = CAUSE_SYS_DEF,
   parameter logic [4:0] CAUSE_BRK = CAUSE_BRK_DEF,
   parameter logic [4:0] CAUSE_TEQ = CAUSE_TEQ_DEF
) (
   input  logic        ex_valid,
   input  logic        ex_syscall,
   input  logic        ex_break,
   input  logic        ex_teq,
   input  logic        ex_eret,
   input  logic        ex_mtc0,
   input  logic        int_pending,
   input  logic [31:0] status,
   output logic        take,
   output logic        is_eret,
   output logic        is_int,
   output logic [4:0]  cause
);

   // Priority chain; an mtc0 in EX holds off the interrupt one cycle so the
   // Status value it writes is the one that qualifies the interrupt.
   always_comb begin
      take    = 1'b0;
      is_eret = 1'b0;
      is_int  = 1'b0;
      cause   = 5'd0;
      if (ex_valid && ex_eret) begin
         take    = 1'b1;
         is_eret = 1'b1;
      end else if (ex_valid && ex_teq && ev_enabled(status, TEQ_EN)) begin
         take  = 1'b1;
         cause = CAUSE_TEQ;
      end else if (ex_valid && ex_break && ev_enabled(status, BRK_EN)) begin
         take  = 1'b1;
         cause = CAUSE_BRK;
      end else if (ex_valid && ex_syscall && ev_enabled(status, SYS_EN)) begin
         take  = 1'b1;
         cause = CAUSE_SYS;
      end else if (int_pending && ev_enabled(status, INT_EN) && !(ex_valid && ex_mtc0)) begin
         take   = 1'b1;
         is_int = 1'b1;
         cause  = CAUSE_INT;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt sequencer: issues one strobe per event, then holds
// flush for a drain window while the pipeline refills from the handler.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int         DRAIN_CYCLES = 2,
   parameter logic [4:0] CAUSE_INT    = CAUSE_INT_DEF,
   parameter logic [4:0] CAUSE_SYS    = CAUSE_SYS_DEF,
   parameter logic [4:0] CAUSE_BRK    = CAUSE_BRK_DEF,
   parameter logic [4:0] CAUSE_TEQ    = CAUSE_TEQ_DEF
) (
   input  logic       clk,
   input  logic       rst,
   exc_ctrl_if.slave  bus
);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        int_pending_q;

   logic        enc_take, enc_is_eret, enc_is_int;
   logic [4:0]  enc_cause;
   logic        take;

   logic        exc_o, eret_o, flush_o, redirect_o, busy_o;
   logic [4:0]  cause_o;
   logic [31:0] pc_o;
   logic        int_strobe;

   exc_prio_enc #(
      .CAUSE_INT (CAUSE_INT),
      .CAUSE_SYS (CAUSE_SYS),
      .CAUSE_BRK (CAUSE_BRK),
      .CAUSE_TEQ (CAUSE_TEQ)
   ) u_prio (
      .ex_valid    (bus.ex_valid),
      .ex_syscall  (bus.ex_syscall),
      .ex_break    (bus.ex_break),
      .ex_teq      (bus.ex_teq),
      .ex_eret     (bus.ex_eret),
      .ex_mtc0     (bus.ex_mtc0),
      .int_pending (int_pending_q),
      .status      (bus.status),
      .take        (enc_take),
      .is_eret     (enc_is_eret),
      .is_int      (enc_is_int),
      .cause       (enc_cause)
   );

   // Strobes are suppressed while reset is held so every output reads 0.
   assign take = enc_take & ~rst;

   // State register and drain counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next-state logic and Mealy outputs; the strobe fires in the event cycle.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      exc_o      = 1'b0;
      eret_o     = 1'b0;
      cause_o    = 5'd0;
      pc_o       = 32'd0;
      flush_o    = 1'b0;
      redirect_o = 1'b0;
      busy_o     = 1'b0;
      int_strobe = 1'b0;
      case (state)
         ST_IDLE: begin
            if (take) begin
               flush_o    = 1'b1;
               redirect_o = 1'b1;
               if (enc_is_eret) begin
                  eret_o = 1'b1;
               end else begin
                  exc_o      = 1'b1;
                  cause_o    = enc_cause;
                  pc_o       = bus.ex_valid ? bus.ex_pc : 32'd0;
                  int_strobe = enc_is_int;
               end
               state_nx = ST_DRAIN;
               cnt_nx   = 4'(DRAIN_CYCLES);
            end
         end
         ST_DRAIN: begin
            flush_o = 1'b1;
            busy_o  = 1'b1;
            if (cnt <= 4'd1) begin
               state_nx = ST_IDLE;
               cnt_nx   = 4'd0;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = 4'd0;
         end
      endcase
   end

   // Interrupt latch: any ext_int cycle sets it, only a serviced interrupt clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_pending_q <= 1'b0;
      end else if (bus.ext_int) begin
         int_pending_q <= 1'b1;
      end else if (int_strobe) begin
         int_pending_q <= 1'b0;
      end
   end

   assign bus.cp0_exception = exc_o;
   assign bus.cp0_eret      = eret_o;
   assign bus.cp0_cause     = cause_o;
   assign bus.cp0_pc        = pc_o;
   assign bus.flush         = flush_o;
   assign bus.redirect      = redirect_o;
   assign bus.busy          = busy_o;
   assign bus.int_pending   = int_pending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Testbench for exc_ctrl: directed scenarios plus a randomized run against
// a cycle-level behavioural model of the exception rules.
module tb_exc_ctrl;

   localparam int DRAIN = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   exc_ctrl_if bus();

   exc_ctrl #(.DRAIN_CYCLES(DRAIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_inputs();
      bus.ex_valid   = 1'b0;
      bus.ex_pc      = 32'd0;
      bus.ex_syscall = 1'b0;
      bus.ex_break   = 1'b0;
      bus.ex_teq     = 1'b0;
      bus.ex_eret    = 1'b0;
      bus.ex_mtc0    = 1'b0;
      bus.ext_int    = 1'b0;
      bus.status     = 32'd0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      bus.ex_valid = 1'b1; bus.ex_syscall = 1'b1; bus.ex_pc = 32'h1234;
      bus.status = 32'h1F; bus.ext_int = 1'b1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_eret, bus.cp0_cause, bus.cp0_pc, bus.flush,
           bus.redirect, bus.busy, bus.int_pending} !== 43'd0)
         $display("FAIL reset_outputs: got exc=%b eret=%b cause=%0d pc=%h flush=%b redir=%b busy=%b pend=%b, want all 0",
                  bus.cp0_exception, bus.cp0_eret, bus.cp0_cause, bus.cp0_pc, bus.flush,
                  bus.redirect, bus.busy, bus.int_pending);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;
   endtask

   task automatic test_syscall();
      do_reset();
      bus.status = 32'h1F; bus.ex_valid = 1'b1; bus.ex_syscall = 1'b1; bus.ex_pc = 32'h0040_0010;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_eret, bus.cp0_cause, bus.cp0_pc, bus.redirect, bus.flush, bus.busy}
          !== {1'b1, 1'b0, 5'd8, 32'h0040_0010, 1'b1, 1'b1, 1'b0})
         $display("FAIL syscall_strobe: got exc=%b eret=%b cause=%0d pc=%h redir=%b flush=%b busy=%b, want 1 0 8 00400010 1 1 0",
                  bus.cp0_exception, bus.cp0_eret, bus.cp0_cause, bus.cp0_pc, bus.redirect, bus.flush, bus.busy);
      else n_pass++;
      for (int i = 0; i < DRAIN; i++) begin
         @(negedge clk);
         bus.ex_syscall = 1'b1;
         #1;
         n_checks++;
         if ({bus.flush, bus.busy, bus.redirect, bus.cp0_exception} !== 4'b1100)
            $display("FAIL syscall_drain%0d: got flush=%b busy=%b redir=%b exc=%b, want 1 1 0 0",
                     i, bus.flush, bus.busy, bus.redirect, bus.cp0_exception);
         else n_pass++;
      end
      @(negedge clk);
      bus.ex_syscall = 1'b0;
      #1;
      n_checks++;
      if ({bus.flush, bus.busy} !== 2'b00)
         $display("FAIL syscall_drain_end: got flush=%b busy=%b, want 0 0", bus.flush, bus.busy);
      else n_pass++;
   endtask

   task automatic test_priority();
      do_reset();
      bus.status = 32'h1F; bus.ex_valid = 1'b1; bus.ex_teq = 1'b1; bus.ex_break = 1'b1;
      bus.ex_pc = 32'h0040_0100;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_cause, bus.cp0_pc} !== {1'b1, 5'd13, 32'h0040_0100})
         $display("FAIL prio_teq: got exc=%b cause=%0d pc=%h, want 1 13 00400100",
                  bus.cp0_exception, bus.cp0_cause, bus.cp0_pc);
      else n_pass++;
      clear_inputs();
      repeat (DRAIN + 1) @(negedge clk);
      bus.status = 32'h17; bus.ex_valid = 1'b1; bus.ex_teq = 1'b1; bus.ex_break = 1'b1;
      bus.ex_pc = 32'h0040_0104;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_cause, bus.cp0_pc} !== {1'b1, 5'd9, 32'h0040_0104})
         $display("FAIL prio_brk: got exc=%b cause=%0d pc=%h, want 1 9 00400104",
                  bus.cp0_exception, bus.cp0_cause, bus.cp0_pc);
      else n_pass++;
      clear_inputs();
      repeat (DRAIN + 1) @(negedge clk);
   endtask

   task automatic test_masked();
      do_reset();
      bus.status = 32'h1D; bus.ex_valid = 1'b1; bus.ex_syscall = 1'b1; bus.ex_pc = 32'h0040_0200;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_eret, bus.flush, bus.redirect, bus.cp0_cause, bus.cp0_pc} !== 41'd0)
         $display("FAIL masked_sys: got exc=%b eret=%b flush=%b redir=%b cause=%0d pc=%h, want all 0",
                  bus.cp0_exception, bus.cp0_eret, bus.flush, bus.redirect, bus.cp0_cause, bus.cp0_pc);
      else n_pass++;
      @(negedge clk);
      clear_inputs();
      #1;
      n_checks++;
      if (bus.busy !== 1'b0)
         $display("FAIL masked_busy: got busy=%b, want 0", bus.busy);
      else n_pass++;
   endtask

   task automatic test_interrupt(input logic [31:0] st, input logic expect_take);
      do_reset();
      bus.status = st; bus.ex_valid = 1'b1; bus.ex_eret = 1'b1;
      @(negedge clk);
      bus.ex_valid = 1'b0; bus.ex_eret = 1'b0; bus.ext_int = 1'b1;
      @(negedge clk);
      bus.ext_int = 1'b0;
      #1;
      n_checks++;
      if ({bus.busy, bus.int_pending, bus.cp0_exception} !== 3'b110)
         $display("FAIL int_latch_st%0h: got busy=%b pend=%b exc=%b, want 1 1 0",
                  st, bus.busy, bus.int_pending, bus.cp0_exception);
      else n_pass++;
      @(negedge clk);
      bus.ex_pc = 32'h0040_0300;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_cause, bus.cp0_pc, bus.redirect}
          !== {expect_take, 5'd0, 32'd0, expect_take})
         $display("FAIL int_take_st%0h: got exc=%b cause=%0d pc=%h redir=%b, want %b 0 0 %b",
                  st, bus.cp0_exception, bus.cp0_cause, bus.cp0_pc, bus.redirect, expect_take, expect_take);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.int_pending, bus.busy} !== {~expect_take, expect_take})
         $display("FAIL int_after_st%0h: got pend=%b busy=%b, want %b %b",
                  st, bus.int_pending, bus.busy, ~expect_take, expect_take);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_eret();
      do_reset();
      bus.status = 32'h0; bus.ex_valid = 1'b1; bus.ex_eret = 1'b1; bus.ex_pc = 32'h8000_0180;
      #1;
      n_checks++;
      if ({bus.cp0_eret, bus.cp0_exception, bus.redirect, bus.flush, bus.cp0_cause, bus.cp0_pc}
          !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0})
         $display("FAIL eret_strobe: got eret=%b exc=%b redir=%b flush=%b cause=%0d pc=%h, want 1 0 1 1 0 0",
                  bus.cp0_eret, bus.cp0_exception, bus.redirect, bus.flush, bus.cp0_cause, bus.cp0_pc);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if ({bus.busy, bus.flush, bus.cp0_eret} !== 3'b110)
         $display("FAIL eret_drain: got busy=%b flush=%b eret=%b, want 1 1 0", bus.busy, bus.flush, bus.cp0_eret);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_mtc0_and_reset();
      do_reset();
      bus.status = 32'h11; bus.ext_int = 1'b1;
      @(negedge clk);
      bus.ext_int = 1'b0; bus.ex_valid = 1'b1; bus.ex_mtc0 = 1'b1; bus.ex_pc = 32'h0040_0400;
      #1;
      n_checks++;
      if ({bus.int_pending, bus.cp0_exception, bus.flush} !== 3'b100)
         $display("FAIL mtc0_defer: got pend=%b exc=%b flush=%b, want 1 0 0",
                  bus.int_pending, bus.cp0_exception, bus.flush);
      else n_pass++;
      @(negedge clk);
      bus.ex_mtc0 = 1'b0; bus.ex_pc = 32'h0040_0404;
      #1;
      n_checks++;
      if ({bus.cp0_exception, bus.cp0_cause, bus.cp0_pc} !== {1'b1, 5'd0, 32'h0040_0404})
         $display("FAIL mtc0_then_int: got exc=%b cause=%0d pc=%h, want 1 0 00400404",
                  bus.cp0_exception, bus.cp0_cause, bus.cp0_pc);
      else n_pass++;
      @(negedge clk);
      bus.ex_valid = 1'b0; bus.ext_int = 1'b1;
      @(negedge clk);
      bus.ext_int = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.flush, bus.busy, bus.int_pending} !== 3'b000)
         $display("FAIL reset_mid_drain: got flush=%b busy=%b pend=%b, want 0 0 0",
                  bus.flush, bus.busy, bus.int_pending);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
   endtask

   task automatic test_random();
      int          m_drain;
      logic        m_pend;
      logic        int_taken;
      logic [42:0] exp_v, got_v;
      logic        v, ev_eret, ev_teq, ev_brk, ev_sys, ev_mtc0, ev_int;
      logic [31:0] st, pc;
      int          kind;
      do_reset();
      m_drain = 0;
      m_pend  = 1'b0;
      for (int c = 0; c < 500; c++) begin
         @(negedge clk);
         v  = ($urandom_range(0, 3) != 0);
         pc = $urandom & 32'hFFFF_FFFC;
         st = {27'd0, 5'($urandom_range(0, 31))};
         if ($urandom_range(0, 3) == 0) st = 32'h1F;
         ev_eret = 1'b0; ev_teq = 1'b0; ev_brk = 1'b0; ev_sys = 1'b0; ev_mtc0 = 1'b0;
         kind = $urandom_range(0, 7);
         case (kind)
            0: ev_eret = ($urandom_range(0, 2) == 0);
            1: ev_teq  = 1'b1;
            2: ev_brk  = 1'b1;
            3: ev_sys  = 1'b1;
            4: ev_mtc0 = 1'b1;
            5: begin ev_teq = $urandom_range(0, 1); ev_brk = $urandom_range(0, 1); ev_sys = $urandom_range(0, 1); end
            default: ;
         endcase
         ev_int = ($urandom_range(0, 9) == 0);
         bus.ex_valid = v; bus.ex_pc = pc; bus.status = st;
         bus.ex_eret = ev_eret; bus.ex_teq = ev_teq; bus.ex_break = ev_brk;
         bus.ex_syscall = ev_sys; bus.ex_mtc0 = ev_mtc0; bus.ext_int = ev_int;
         #1;
         // Expected: {exc, eret, cause, pc, flush, redirect, busy, int_pending}
         exp_v = 43'd0;
         int_taken = 1'b0;
         exp_v[0] = m_pend;
         if (m_drain > 0) begin
            exp_v[3] = 1'b1;
            exp_v[1] = 1'b1;
         end else if (v && ev_eret) begin
            exp_v[41] = 1'b1;
         end else if (v && ev_teq && st[0] && st[3]) begin
            exp_v[42] = 1'b1; exp_v[40:36] = 5'd13; exp_v[35:4] = pc;
         end else if (v && ev_brk && st[0] && st[2]) begin
            exp_v[42] = 1'b1; exp_v[40:36] = 5'd9; exp_v[35:4] = pc;
         end else if (v && ev_sys && st[0] && st[1]) begin
            exp_v[42] = 1'b1; exp_v[40:36] = 5'd8; exp_v[35:4] = pc;
         end else if (m_pend && st[0] && st[4] && !(v && ev_mtc0)) begin
            exp_v[42] = 1'b1; exp_v[40:36] = 5'd0; exp_v[35:4] = v ? pc : 32'd0;
            int_taken = 1'b1;
         end
         if (exp_v[42] || exp_v[41]) begin
            exp_v[3] = 1'b1;
            exp_v[2] = 1'b1;
         end
         got_v = {bus.cp0_exception, bus.cp0_eret, bus.cp0_cause, bus.cp0_pc,
                  bus.flush, bus.redirect, bus.busy, bus.int_pending};
         n_checks++;
         if (got_v !== exp_v)
            $display("FAIL random_cycle%0d: got %h, want %h (exc,eret,cause,pc,flush,redir,busy,pend)",
                     c, got_v, exp_v);
         else n_pass++;
         if (exp_v[42] || exp_v[41]) m_drain = DRAIN;
         else if (m_drain > 0) m_drain--;
         if (ev_int) m_pend = 1'b1;
         else if (int_taken) m_pend = 1'b0;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_syscall();
      test_priority();
      test_masked();
      test_interrupt(32'h11, 1'b1);
      test_interrupt(32'h00, 1'b0);
      test_eret();
      test_mtc0_and_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
Exception/interrupt sequencer for CP0 in the dynamic pipeline CPU. Collects the syscall/break/teq/eret/mtc0 events flagged in EX and an external interrupt line, qualifies them against the CP0 Status mask, and issues one mutually exclusive strobe (exception or eret) to CP0 per event. It also drives the pipeline flush, the PC redirect and a drain window that blocks new events while the pipeline refills.

Parameters:
DRAIN_CYCLES, 2, cycles flush stays asserted after the strobe cycle (1..15)
CAUSE_INT, 5'd0, cause code for external interrupt
CAUSE_SYS, 5'd8, cause code for syscall
CAUSE_BRK, 5'd9, cause code for break
CAUSE_TEQ, 5'd13, cause code for teq trap

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX stage holds a real (non-bubble) instruction
ex_pc  in  32  PC of the EX instruction
ex_syscall  in  1  EX instruction is syscall
ex_break  in  1  EX instruction is break
ex_teq  in  1  EX instruction is teq and rs==rt
ex_eret  in  1  EX instruction is eret
ex_mtc0  in  1  EX instruction is mtc0
ext_int  in  1  external interrupt request, level
status  in  32  CP0 Status register
cp0_exception  out  1  exception strobe to CP0
cp0_eret  out  1  eret strobe to CP0
cp0_cause  out  5  cause code to CP0
cp0_pc  out  32  EPC value to CP0
flush  out  1  kill IF/ID/EX contents
redirect  out  1  PC mux selects CP0 exception_addr this cycle
busy  out  1  controller in drain window
int_pending  out  1  latched interrupt awaiting service

Behaviour:
- Reset (async): state IDLE, drain count 0, int_pending 0; all outputs 0, cp0_cause 0, cp0_pc 0.
- Status mask: bit0 = global enable IE; bit1 syscall, bit2 break, bit3 teq, bit4 interrupt enable. Event enabled only if status[0] and its own bit are 1. CP0 shifts Status left by 5 on exception, so nested exceptions are masked automatically; eret shifts right to restore.
- int_pending: set on any cycle with ext_int=1; cleared only in the cycle an interrupt strobe is issued; unaffected by masking or busy.
- States: IDLE, DRAIN.
- IDLE, priority when ex_valid=1: eret > teq > break > syscall > interrupt. eret is never masked. Interrupt needs int_pending, status[0] and status[4]; it is taken with or without ex_valid, except when ex_valid and ex_mtc0 are both 1.
- Strobe cycle (Mealy, same cycle as event in IDLE): exactly one of cp0_exception or cp0_eret = 1; flush=1; redirect=1. For an exception: cp0_cause = matching code, cp0_pc = ex_pc if ex_valid else 0.
- For a synchronous exception, EPC = PC of the trapping instruction. For an interrupt, EPC = ex_pc, and that instruction is killed and re-executed after eret.
- Next edge after strobe: state DRAIN, count = DRAIN_CYCLES.
- DRAIN: flush=1, busy=1, redirect=0, no strobes. All ex_* inputs ignored (they are being flushed); count decrements each cycle; at count==1 → IDLE.
- cp0_cause and cp0_pc are 0 whenever cp0_exception=0.
- Masked synchronous exception: no strobe, no flush; instruction completes as a nop.
- ex_mtc0 and a same-instruction exception cannot coexist. mtc0 only defers interrupts, one cycle, so the new Status applies first.
- ex_valid=0: all ex_* event flags are ignored.
- Reset mid-DRAIN: immediate return to IDLE, flush drops, int_pending clears.

Decomposition:
- Shared package: cause code constants, Status bit indices (IE, SYS_EN, BRK_EN, TEQ_EN, INT_EN), state encoding.
- One natural sub-module: exc_prio_enc, the combinational priority/mask encoder producing take, is_eret and cause.
- FSM, drain counter and int_pending latch stay in exc_ctrl.

Test Plan:
1. status=0x1F, ex_valid=1, ex_syscall=1, ex_pc=0x00400010 → same cycle cp0_exception=1, cp0_cause=8, cp0_pc=0x00400010, redirect=1; flush high 3 cycles total, busy high 2.
2. status=0x1F, ex_teq=1 and ex_break=1 together → cause=13; with status=0x17 (teq masked) → cause=9.
3. status=0x1D (syscall masked), ex_syscall=1 → no strobe, flush=0, redirect=0.
4. status=0x11, ext_int pulse 1 cycle while busy → int_pending=1. First IDLE cycle: cp0_exception=1, cause=0, int_pending→0. Repeat with status=0x00 → int_pending stays 1, no strobe.
5. ex_eret=1 with status=0 (post-exception shifted) → cp0_eret=1, cp0_exception=0, redirect=1, then DRAIN.
6. ex_mtc0=1 with int_pending=1 and status=0x11 → no strobe that cycle; strobe next cycle. Assert rst mid-DRAIN → flush, busy, int_pending all 0 immediately.
